// File: rtl/star_pkg.sv
// Shared definitions for the win-screen star row (sequencer, renderer, gamelogic).
// Holds the default row width, the reveal FSM state type and the coin polarity.
// Pure declarations, no logic.
package star_pkg;

  localparam int NUM_STARS = 3;

  // CoinStatus bit value meaning "coin has been picked up"
  localparam logic COIN_COLLECTED = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLASH,
    DONE
  } star_reveal_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the vsync-rate frame level into a single-cycle tick on each rising edge.
// Latency: tick is combinational from frame_clk against one registered sample.
// No backpressure; one tick per rising edge, never more.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_clk_q;

  // Previous-cycle sample of the frame level for rising-edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_clk_q <= 1'b0;
    else          frame_clk_q <= frame_clk;
  end

  assign frame_tick = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/star_reveal_ctrl.sv
// Win-screen star sequencer: latches collected coins, lights stars left to right with a flash.
// Latency: every output is registered and updates the cycle after its cause.
// No backpressure; restart overrides everything, win_start only honoured in IDLE.
module star_reveal_ctrl #(
  parameter int NUM_STARS       = star_pkg::NUM_STARS,
  parameter int FRAMES_PER_STAR = 30,
  parameter int FLASH_FRAMES    = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk,
  input  logic                 win_start,
  input  logic                 restart,
  input  logic [NUM_STARS-1:0] CoinStatus,
  output logic [NUM_STARS-1:0] star_lit,
  output logic [NUM_STARS-1:0] star_flash,
  output logic [1:0]           collected_cnt,
  output logic                 reveal_done
);

  import star_pkg::*;

  localparam int CW = $clog2(FRAMES_PER_STAR + 1);
  localparam logic [CW-1:0] FPS_C   = CW'(FRAMES_PER_STAR);
  localparam logic [CW-1:0] FLASH_C = CW'(FLASH_FRAMES);

  star_reveal_state_t state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;
  logic [1:0]         idx;
  logic [1:0]         zero_cnt;
  logic               frame_tick;

  frame_tick_gen u_tick (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // Number of collected coins, saturating at 3 to fit the 2-bit count
  always_comb begin
    zero_cnt = 2'd0;
    for (int i = 0; i < NUM_STARS; i++) begin
      if (CoinStatus[i] == COIN_COLLECTED && zero_cnt != 2'd3) zero_cnt = zero_cnt + 2'd1;
    end
  end

  // Frame counter next value; sticks at FRAMES_PER_STAR rather than wrapping
  always_comb begin
    cnt_inc = (cnt == FPS_C) ? cnt : cnt + CW'(1);
  end

  // Reveal FSM with registered outputs; restart takes priority over any tick or win event
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      star_lit      <= '0;
      star_flash    <= '0;
      collected_cnt <= 2'd0;
      reveal_done   <= 1'b0;
      cnt           <= '0;
      idx           <= 2'd0;
    end else if (restart) begin
      state         <= IDLE;
      star_lit      <= '0;
      star_flash    <= '0;
      collected_cnt <= 2'd0;
      reveal_done   <= 1'b0;
      cnt           <= '0;
      idx           <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_start) begin
            collected_cnt <= zero_cnt;
            idx           <= 2'd0;
            cnt           <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (frame_tick) begin
            if (cnt_inc == FPS_C) begin
              if (idx < collected_cnt) begin
                star_lit[idx] <= 1'b1;
                star_flash    <= NUM_STARS'(1) << idx;
                cnt           <= '0;
                state         <= FLASH;
              end else begin
                // Only reachable with nothing collected: empty row, straight to done
                cnt   <= cnt_inc;
                state <= DONE;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        FLASH: begin
          if (frame_tick) begin
            // Counter is kept on leaving so WAIT only covers the rest of the gap
            cnt <= cnt_inc;
            if (cnt_inc == FLASH_C) begin
              star_flash <= '0;
              idx        <= idx + 2'd1;
              state      <= (idx + 2'd1 == collected_cnt) ? DONE : WAIT;
            end
          end
        end
        DONE: begin
          reveal_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_star_reveal_ctrl.sv
// Directed bench for star_reveal_ctrl with FRAMES_PER_STAR=4, FLASH_FRAMES=2.
// Inputs driven on the falling clock edge, outputs sampled on the falling edge.
// Expected values are hand-derived constants per step.
module tb_star_reveal_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       win_start = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] CoinStatus = 3'b000;
  logic [2:0] star_lit;
  logic [2:0] star_flash;
  logic [1:0] collected_cnt;
  logic       reveal_done;

  int checks = 0;
  int errors = 0;

  star_reveal_ctrl #(
    .NUM_STARS       (3),
    .FRAMES_PER_STAR (4),
    .FLASH_FRAMES    (2)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_clk     (frame_clk),
    .win_start     (win_start),
    .restart       (restart),
    .CoinStatus    (CoinStatus),
    .star_lit      (star_lit),
    .star_flash    (star_flash),
    .collected_cnt (collected_cnt),
    .reveal_done   (reveal_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] lit, input logic [2:0] fl,
                           input logic [1:0] cc, input logic dn);
    check({tag, ".lit"},   32'(star_lit),      32'(lit));
    check({tag, ".flash"}, 32'(star_flash),    32'(fl));
    check({tag, ".cnt"},   32'(collected_cnt), 32'(cc));
    check({tag, ".done"},  32'(reveal_done),   32'(dn));
  endtask

  // One frame rising edge; returns one clock after the edge was consumed
  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_win();
    @(negedge Clk) win_start = 1'b1;
    @(negedge Clk) win_start = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge Clk) restart = 1'b1;
    @(negedge Clk) restart = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge Clk);
    check_all("reset", 3'b000, 3'b000, 2'd0, 1'b0);
    Reset_n = 1'b1;

    // All three coins collected
    CoinStatus = 3'b000;
    pulse_win();
    check_all("full.latch", 3'b000, 3'b000, 2'd3, 1'b0);
    ticks(3);
    check_all("full.t3", 3'b000, 3'b000, 2'd3, 1'b0);
    tick();
    check_all("full.t4", 3'b001, 3'b001, 2'd3, 1'b0);
    tick();
    check_all("full.t5", 3'b001, 3'b001, 2'd3, 1'b0);
    tick();
    check_all("full.t6", 3'b001, 3'b000, 2'd3, 1'b0);
    tick();
    check_all("full.t7", 3'b001, 3'b000, 2'd3, 1'b0);
    tick();
    check_all("full.t8", 3'b011, 3'b010, 2'd3, 1'b0);
    ticks(2);
    check_all("full.t10", 3'b011, 3'b000, 2'd3, 1'b0);
    ticks(2);
    check_all("full.t12", 3'b111, 3'b100, 2'd3, 1'b0);
    tick();
    check_all("full.t13", 3'b111, 3'b100, 2'd3, 1'b0);
    tick();
    check_all("full.t14", 3'b111, 3'b000, 2'd3, 1'b0);
    @(negedge Clk);
    check_all("full.done", 3'b111, 3'b000, 2'd3, 1'b1);
    ticks(3);
    check_all("full.hold", 3'b111, 3'b000, 2'd3, 1'b1);
    pulse_restart();
    check_all("full.restart", 3'b000, 3'b000, 2'd0, 1'b0);

    // One coin collected
    CoinStatus = 3'b101;
    pulse_win();
    check_all("one.latch", 3'b000, 3'b000, 2'd1, 1'b0);
    ticks(4);
    check_all("one.t4", 3'b001, 3'b001, 2'd1, 1'b0);
    ticks(2);
    check_all("one.t6", 3'b001, 3'b000, 2'd1, 1'b0);
    @(negedge Clk);
    check_all("one.done", 3'b001, 3'b000, 2'd1, 1'b1);
    ticks(8);
    check_all("one.hold", 3'b001, 3'b000, 2'd1, 1'b1);
    pulse_restart();

    // No coins collected
    CoinStatus = 3'b111;
    pulse_win();
    check_all("none.latch", 3'b000, 3'b000, 2'd0, 1'b0);
    ticks(4);
    check_all("none.t4", 3'b000, 3'b000, 2'd0, 1'b0);
    @(negedge Clk);
    check_all("none.done", 3'b000, 3'b000, 2'd0, 1'b1);
    pulse_restart();

    // Second win_start in WAIT ignored, then restart coincident with a frame tick
    CoinStatus = 3'b000;
    pulse_win();
    tick();
    CoinStatus = 3'b111;
    pulse_win();
    check_all("rwin.ignored", 3'b000, 3'b000, 2'd3, 1'b0);
    ticks(7);
    check_all("rwin.t8", 3'b011, 3'b010, 2'd3, 1'b0);
    @(negedge Clk) begin frame_clk = 1'b1; restart = 1'b1; end
    @(negedge Clk) begin frame_clk = 1'b0; restart = 1'b0; end
    check_all("rtick.cleared", 3'b000, 3'b000, 2'd0, 1'b0);
    ticks(5);
    check_all("rtick.idle", 3'b000, 3'b000, 2'd0, 1'b0);
    CoinStatus = 3'b110;
    pulse_win();
    ticks(3);
    check_all("rtick.re_t3", 3'b000, 3'b000, 2'd1, 1'b0);
    tick();
    check_all("rtick.re_t4", 3'b001, 3'b001, 2'd1, 1'b0);
    pulse_restart();

    // CoinStatus changes after win_start are ignored; async reset mid-FLASH
    CoinStatus = 3'b000;
    pulse_win();
    CoinStatus = 3'b111;
    ticks(2);
    CoinStatus = 3'b010;
    ticks(2);
    check_all("toggle.t4", 3'b001, 3'b001, 2'd3, 1'b0);
    tick();
    @(negedge Clk) Reset_n = 1'b0;
    #1;
    check_all("areset", 3'b000, 3'b000, 2'd0, 1'b0);
    @(negedge Clk) Reset_n = 1'b1;
    ticks(6);
    check_all("areset.idle", 3'b000, 3'b000, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
